divider: RTL and testbench

//  Iterative restoring integer divider for the RV32M DIV/DIVU/REM/REMU path.
//  It is the inverse companion of the shift-add multiplier and uses the same

---
 rtl/alu_pkg.sv | 12 +
 rtl/divider.sv | 124 ++++++++++++
 tb/tb_divider.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared execute-stage definitions for the iterative multiply/divide units.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FINISH
  } div_state_t;

endpackage

// File: rtl/divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with a compute/cancel/busy handshake shared with the shift-add multiplier.
module divider
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic             s_compute_i,
  input  logic             s_cancel_i,
  input  logic             s_signed_i,
  input  logic [WIDTH-1:0] s_dividend_i,
  input  logic [WIDTH-1:0] s_divisor_i,
  output logic             s_busy_o,
  output logic             s_done_o,
  output logic [WIDTH-1:0] s_quotient_o,
  output logic [WIDTH-1:0] s_remainder_o
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_state_t       state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             qneg, rneg;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero;

  assign a_mag    = cond_neg(s_dividend_i, s_signed_i & s_dividend_i[WIDTH-1]);
  assign b_mag    = cond_neg(s_divisor_i,  s_signed_i & s_divisor_i[WIDTH-1]);
  assign div_zero = (s_divisor_i == '0);

  // The shifted partial remainder needs one extra bit; the difference always fits WIDTH bits.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, dvs});
  assign rem_diff = rem_sh[WIDTH-1:0] - dvs;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state <= DIV_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:   if (s_compute_i) state_nxt = div_zero ? DIV_FINISH : DIV_CALC;
      DIV_CALC: begin
        if (s_cancel_i)             state_nxt = DIV_IDLE;
        else if (count == CW'(1))   state_nxt = DIV_FINISH;
      end
      DIV_FINISH: state_nxt = DIV_IDLE;
      default:    state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      count         <= '0;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      qneg          <= 1'b0;
      rneg          <= 1'b0;
      s_busy_o      <= 1'b0;
      s_done_o      <= 1'b0;
      s_quotient_o  <= '0;
      s_remainder_o <= '0;
    end else begin
      s_done_o <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (s_compute_i) begin
            dvs      <= b_mag;
            qneg     <= s_signed_i & (s_dividend_i[WIDTH-1] ^ s_divisor_i[WIDTH-1]) & ~div_zero;
            rneg     <= s_signed_i & s_dividend_i[WIDTH-1];
            count    <= CW'(WIDTH);
            s_busy_o <= 1'b1;
            // Divide-by-zero skips the iteration: all-ones quotient, dividend as remainder.
            if (div_zero) begin
              quo <= '1;
              rem <= a_mag;
            end else begin
              quo <= a_mag;
              rem <= '0;
            end
          end
        end
        DIV_CALC: begin
          if (s_cancel_i) begin
            s_busy_o      <= 1'b0;
            s_quotient_o  <= '0;
            s_remainder_o <= '0;
          end else begin
            rem   <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], rem_ge};
            count <= count - CW'(1);
          end
        end
        DIV_FINISH: begin
          s_busy_o <= 1'b0;
          if (s_cancel_i) begin
            s_quotient_o  <= '0;
            s_remainder_o <= '0;
          end else begin
            s_quotient_o  <= cond_neg(quo, qneg);
            s_remainder_o <= cond_neg(rem, rneg);
            s_done_o      <= 1'b1;
          end
        end
        default: s_busy_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider against a RISC-V M reference model.
module tb_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [7:0]   cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn, compute, cancel, sgn;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  divider #(.WIDTH(W)) dut (
    .s_clk_i      (clk),
    .s_resetn_i   (resetn),
    .s_compute_i  (compute),
    .s_cancel_i   (cancel),
    .s_signed_i   (sgn),
    .s_dividend_i (dividend),
    .s_divisor_i  (divisor),
    .s_busy_o     (busy),
    .s_done_o     (done),
    .s_quotient_o (quotient),
    .s_remainder_o(remainder)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.cyc = 8'd33;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.cyc = 8'd1;
    end else if (s) begin
      if (a == MIN && b == '1) begin
        e.q = MIN;
        e.r = '0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Entered and left on a falling edge; on return the done cycle is current.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    exp_t e;
    int   n;
    compute  = 1'b1;
    sgn      = s;
    dividend = a;
    divisor  = b;
    sb.push_back(model(s, a, b));
    @(negedge clk);
    compute = 1'b0;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (poke && n == 5) begin
        compute  = 1'b1;
        sgn      = ~s;
        dividend = 32'h0000_1234;
        divisor  = 32'h0000_0003;
      end else begin
        compute = 1'b0;
      end
      @(negedge clk);
    end
    compute = 1'b0;
    e = sb.pop_front();
    check({tag, "_busy_cycles"}, 32'(n), 32'(e.cyc));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_quotient"}, quotient, e.q);
    check({tag, "_remainder"}, remainder, e.r);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    resetn   = 1'b0;
    compute  = 1'b0;
    cancel   = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("u100_7",   1'b0, 32'd100, 32'd7, 1'b0);
    run_op("s_m7_2",   1'b1, -32'sd7, 32'd2, 1'b0);
    run_op("s_7_m2",   1'b1, 32'd7, -32'sd2, 1'b0);
    run_op("s5_0",     1'b1, 32'd5, 32'd0, 1'b0);
    run_op("u5_0",     1'b0, 32'd5, 32'd0, 1'b0);
    run_op("s_m5_0",   1'b1, -32'sd5, 32'd0, 1'b0);
    run_op("smin_m1",  1'b1, MIN, 32'hFFFF_FFFF, 1'b0);
    run_op("umin_m1",  1'b0, MIN, 32'hFFFF_FFFF, 1'b0);
    run_op("poke_busy", 1'b0, 32'd1000, 32'd10, 1'b1);

    // Cancel in the 10th CALC cycle; outputs currently hold q=100.
    compute  = 1'b1;
    sgn      = 1'b0;
    dividend = 32'd12345;
    divisor  = 32'd7;
    @(negedge clk);
    compute = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_done", 32'(done), 32'd0);
    check("cancel_quotient", quotient, '0);
    check("cancel_remainder", remainder, '0);
    @(negedge clk);
    check("cancel_no_done", 32'(done), 32'd0);

    run_op("u20_3", 1'b0, 32'd20, 32'd3, 1'b0);

    // Asynchronous reset while iterating; outputs currently hold q=6, r=2.
    compute  = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd5;
    @(negedge clk);
    compute = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_quotient", quotient, '0);
    check("async_rst_remainder", remainder, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if (i % 4 == 1)      rb = '0;
      else if (i % 3 == 0) rb = $urandom_range(1, 15);
      else                 rb = $urandom;
      if (i % 5 == 2)      rb = -rb;
      run_op($sformatf("rand%0d", i), rs, ra, rb, 1'b0);
    end

    @(negedge clk);
    check("final_done_low", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
